// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks a one-hot column drive and latches the
// active-low row sense of each column into a 16-bit pressed-key bitmap.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  column,
    input  logic [3:0]  row,
    output logic [15:0] value,
    output logic        any_pressed
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    logic [15:0] div_count;

    // NOTE: all state is registered with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            column    <= 4'b1000;
            value     <= 16'h0000;
            div_count <= 16'd0;
        end else if (div_count == DIV_LAST) begin
            // Only the nibble of the column driven during this edge is refreshed.
            for (int c = 0; c < 4; c++) begin
                if (column[3-c]) begin
                    value[15-4*c -: 4] <= ~row;
                end
            end
            column    <= {column[0], column[3:1]};
            div_count <= 16'd0;
        end else begin
            div_count <= div_count + 16'd1;
        end
    end

    assign any_pressed = |value;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner at SCAN_DIV=1 and SCAN_DIV=3, checked
// against an arithmetic model of the scan schedule.
module tb_keypad_scanner;

    logic        clk;
    logic        clk_en;
    logic        reset;
    logic [3:0]  row1, row3;
    logic [3:0]  column1, column3;
    logic [15:0] value1, value3;
    logic        any1, any3;

    keypad_scanner #(.SCAN_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .column(column1), .row(row1),
        .value(value1), .any_pressed(any1)
    );

    keypad_scanner #(.SCAN_DIV(3)) dut3 (
        .clk(clk), .reset(reset), .column(column3), .row(row3),
        .value(value3), .any_pressed(any3)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edge count since reset, divider per instance, and the
    // last captured nibble per column.
    int          div[2] = '{1, 3};
    int          k[2];
    logic [3:0]  nib[2][4];

    function automatic void model_reset();
        for (int u = 0; u < 2; u++) begin
            k[u] = 0;
            for (int c = 0; c < 4; c++) nib[u][c] = 4'h0;
        end
    endfunction

    function automatic void model_edge(input int u, input logic [3:0] r);
        int idx;
        idx = ((k[u]) / div[u]) % 4;
        k[u] = k[u] + 1;
        if (k[u] % div[u] == 0) nib[u][idx] = ~r;
    endfunction

    function automatic logic [3:0] exp_col(input int u);
        logic [3:0] one;
        one = 4'b1000;
        return one >> ((k[u] / div[u]) % 4);
    endfunction

    function automatic logic [15:0] exp_val(input int u);
        return {nib[u][0], nib[u][1], nib[u][2], nib[u][3]};
    endfunction

    typedef struct {
        logic [3:0]  c1;
        logic [15:0] v1;
        logic [3:0]  c3;
        logic [15:0] v3;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            check("col_div1", {28'd0, column1}, {28'd0, mon_e.c1});
            check("val_div1", {16'd0, value1}, {16'd0, mon_e.v1});
            check("any_div1", {31'd0, any1}, {31'd0, mon_e.v1 != 16'h0});
            check("col_div3", {28'd0, column3}, {28'd0, mon_e.c3});
            check("val_div3", {16'd0, value3}, {16'd0, mon_e.v3});
            check("any_div3", {31'd0, any3}, {31'd0, mon_e.v3 != 16'h0});
        end
    end

    // Called with clk low: drives rows, predicts the next edge, waits it out.
    task automatic cycle(input logic [3:0] r1, input logic [3:0] r3);
        exp_t e;
        row1 = r1;
        row3 = r3;
        model_edge(0, r1);
        model_edge(1, r3);
        e.c1 = exp_col(0);
        e.v1 = exp_val(0);
        e.c3 = exp_col(1);
        e.v3 = exp_val(1);
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        clk_en = 1'b0;
        reset  = 1'b1;
        row1   = 4'hF;
        row3   = 4'hF;
        model_reset();

        // Reset with the clock stopped.
        #20;
        check("rst_col1", {28'd0, column1}, 32'h8);
        check("rst_val1", {16'd0, value1}, 32'h0);
        check("rst_any1", {31'd0, any1}, 32'h0);
        check("rst_col3", {28'd0, column3}, 32'h8);
        check("rst_val3", {16'd0, value3}, 32'h0);
        reset = 1'b0;
        #5;
        clk_en = 1'b1;

        // Idle column walk.
        for (int i = 0; i < 5; i++) cycle(4'hF, 4'hF);

        // Single-key sweep: each row in turn for one full scan at SCAN_DIV=1.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] one;
            one = 4'b1000;
            cycle(~(one >> (i / 4)), 4'($urandom_range(0, 15)));
        end

        // Release.
        for (int i = 0; i < 16; i++) cycle(4'hF, 4'hF);
        check("release_val", {16'd0, value1}, 32'h0);
        check("release_any", {31'd0, any1}, 32'h0);

        // Multi-key.
        for (int i = 0; i < 4; i++) cycle(4'b0101, 4'hF);
        check("multi_aaaa", {16'd0, value1}, 32'hAAAA);
        check("multi_any", {31'd0, any1}, 32'h1);
        for (int i = 0; i < 4; i++) cycle(4'b1110, 4'hF);
        check("multi_1111", {16'd0, value1}, 32'h1111);

        // Divider: row 0 held for twelve cycles at SCAN_DIV=3.
        for (int i = 0; i < 12; i++) cycle(4'hF, 4'b0111);
        check("div3_8888", {16'd0, value3}, 32'h8888);

        // Randomized rows with random hold lengths.
        for (int i = 0; i < 60; i++) begin
            logic [3:0] r1, r3;
            int hold;
            r1   = 4'($urandom_range(0, 15));
            r3   = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 6);
            for (int j = 0; j < hold; j++) cycle(r1, r3);
        end

        // Reset mid-scan with column 2 driven and a non-zero bitmap.
        for (int i = 0; i < 4; i++) cycle(4'h0, 4'h0);
        for (int i = 0; i < 4 && (k[0] % 4) != 2; i++) cycle(4'h0, 4'h0);
        check("pre_mid_col", {28'd0, column1}, 32'h2);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_col1", {28'd0, column1}, 32'h8);
        check("mid_rst_val1", {16'd0, value1}, 32'h0);
        check("mid_rst_any1", {31'd0, any1}, 32'h0);
        check("mid_rst_col3", {28'd0, column3}, 32'h8);
        check("mid_rst_val3", {16'd0, value3}, 32'h0);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

        @(posedge clk);
        #2;
        check("queue_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad for the CHIP-8 core.
- Drives one column high at a time and reads the four active-low row lines.
- Latches the state of each column into a 16-bit pressed-key bitmap that the CPU reads.
- Sits between the board keypad pins and the CPU key-input logic.

Parameters:
- SCAN_DIV, default 1: clock cycles each column stays driven before the scan advances. Legal range 1..65535.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- column  output  4  one-hot, active-high column drive. Bit 3 is column 0; bit 0 is column 3.
- row  input  4  active-low row sense. Bit 3 is row 0; bit 0 is row 3. A low bit means a key in that row of the driven column is pressed.
- value  output  16  pressed-key bitmap, 1 = pressed. Column c occupies value[15-4c : 12-4c]. Within a nibble, bit 3 is row 0 and bit 0 is row 3.
- any_pressed  output  1  high when value is non-zero. Combinational from value.

Behaviour:
- Reset (asynchronous, on reset high):
  - column = 4'b1000, i.e. column 0 driven.
  - value = 16'h0000.
  - Scan-divider counter = 0.
  - Outputs hold these values while reset is high. Scanning resumes on the first rising clk edge after reset deasserts.
- Column sequence: 1000 -> 0100 -> 0010 -> 0001 -> 1000. Wraps forever.
- column is always exactly one-hot. No all-zero state and no multi-hot state.
- Scan step: occurs on the rising edge where the divider counter equals SCAN_DIV-1. Otherwise the counter increments. At a scan step:
  - The nibble of value for the currently driven column c is loaded with ~row, as sampled at that edge.
  - column rotates right by one.
  - The divider counter resets to 0.
- With SCAN_DIV=1, a step occurs on every clock edge, so column changes every cycle.
- Only the nibble of the column being scanned is written. The other 12 bits hold.
- Latency: a row change is reflected in value at the first scan step of the affected column at or after the change. Worst case is 4*SCAN_DIV cycles.
- No row synchronizer or debounce inside the block. row must be stable across the sampling edge; synchronization is done at the top level.
- Release: after all rows return to 4'b1111, value reaches 0 within one full scan of 4*SCAN_DIV cycles. All nibbles are 0 within 16 cycles at SCAN_DIV=1.
- Multiple keys: any combination of row bits is captured as-is. There is no ghosting suppression.
- Reset mid-scan: returns immediately to column 0, clears value, and restarts the divider.
- Implementation: registered column, value and counter.

Test Plan:
- Reset: assert reset with clk stopped -> column=4'b1000, value=16'h0000, any_pressed=0. Release reset, idle row=4'b1111 -> column walks 1000, 0100, 0010, 0001, 1000 on successive rising edges.
- Single-key sweep, SCAN_DIV=1: for each row r in 0..3 and column c in 0..3, drive row=~(4'b1000>>r) while column c is driven -> after that edge, value[15-4c:12-4c] = 4'b1000>>r.
- Release: after the sweep, set row=4'b1111 and wait 16 cycles -> value=16'h0000 and any_pressed=0.
- Multi-key: hold row=4'b0101 for a full scan -> value=16'hAAAA and any_pressed=1. Then set row=4'b1110 and run a full scan -> value=16'h1111.
- Divider, SCAN_DIV=3: column changes every 3 cycles. Holding row=4'b0111 for 12 cycles -> value=16'h8888.
- Reset mid-scan: with value non-zero and column=4'b0010, pulse reset asynchronously between clock edges -> column=4'b1000 and value=0 immediately, before the next edge.
